// File: rtl/split4_pkg.sv
// Shared types and constants for the 16-bit to 4x4-bit beat splitter.
package split4_pkg;

    localparam int unsigned BEATS  = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CHK_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/split4_chk.sv
// Running nibble accumulator; the completed 4-beat sum is latched on the last beat.
module split4_chk
    import split4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_beat,
    input  logic             i_first,
    input  logic             i_last,
    input  logic [NIB_W-1:0] i_nib,
    output logic [CHK_W-1:0] o_chk
);

    logic [CHK_W-1:0] r_acc;
    logic [CHK_W-1:0] r_chk;
    logic [CHK_W-1:0] w_sum;

    // Beat 0 restarts the sum so no separate clear cycle is needed between frames
    assign w_sum = (i_first ? '0 : r_acc) + {{(CHK_W-NIB_W){1'b0}}, i_nib};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_chk <= '0;
        end else if (i_beat) begin
            r_acc <= w_sum;
            if (i_last)
                r_chk <= w_sum;
        end
    end

    assign o_chk = r_chk;

endmodule

// File: rtl/split_4cycle.sv
// Splits a 16-bit word into four registered nibble beats; SPLIT4_CHECKSUM_EN adds the frame checksum.
module split_4cycle
    import split4_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] word,
    input  logic              load,
    output logic              ready,
    output logic [NIB_W-1:0]  data,
    output logic              valid,
    output logic              first,
    output logic              last,
    output logic [CHK_W-1:0]  chk,
    output logic              done
);

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [WORD_W-1:0] r_shift;

    logic              w_accept;
    logic [NIB_W-1:0]  w_load_nib;
    logic [WORD_W-1:0] w_load_shift;
    logic [NIB_W-1:0]  w_next_nib;
    logic [WORD_W-1:0] w_adv_shift;

    assign w_accept = load && ready;

    // The shift register holds only the not-yet-emitted nibbles; beat 0 goes straight to data
    assign w_load_nib   = MSB_FIRST ? word[WORD_W-1 -: NIB_W] : word[NIB_W-1:0];
    assign w_load_shift = MSB_FIRST ? {word[WORD_W-NIB_W-1:0], {NIB_W{1'b0}}}
                                    : {{NIB_W{1'b0}}, word[WORD_W-1:NIB_W]};
    assign w_next_nib   = MSB_FIRST ? r_shift[WORD_W-1 -: NIB_W] : r_shift[NIB_W-1:0];
    assign w_adv_shift  = MSB_FIRST ? {r_shift[WORD_W-NIB_W-1:0], {NIB_W{1'b0}}}
                                    : {{NIB_W{1'b0}}, r_shift[WORD_W-1:NIB_W]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            data    <= '0;
            valid   <= 1'b0;
            first   <= 1'b0;
            last    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= (r_state == SEND) && (r_cnt == 2'd3);
            if (w_accept) begin
                r_state <= SEND;
                r_cnt   <= '0;
                r_shift <= w_load_shift;
                data    <= w_load_nib;
                valid   <= 1'b1;
                first   <= 1'b1;
                last    <= 1'b0;
                ready   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        data  <= '0;
                        valid <= 1'b0;
                        first <= 1'b0;
                        last  <= 1'b0;
                        ready <= 1'b1;
                    end
                    SEND: begin
                        if (r_cnt == 2'd3) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            data    <= '0;
                            valid   <= 1'b0;
                            first   <= 1'b0;
                            last    <= 1'b0;
                            ready   <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt + 2'd1;
                            r_shift <= w_adv_shift;
                            data    <= w_next_nib;
                            first   <= 1'b0;
                            last    <= (r_cnt == 2'd2);
                            ready   <= (r_cnt == 2'd2);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef SPLIT4_CHECKSUM_EN
    logic [CHK_W-1:0] w_chk;

    split4_chk u_chk (
        .clk     (clk),
        .rst     (reset),
        .i_beat  (valid),
        .i_first (first),
        .i_last  (last),
        .i_nib   (data),
        .o_chk   (w_chk)
    );

    assign chk = w_chk;
`else
    assign chk = '0;
`endif

endmodule
